// File: rtl/ram_sp_sync.sv
// Single-port synchronous RAM with registered read data, a read-valid flag
// and a clear engine that sweeps every word to INIT_VAL after reset or on
// request, so the data path never sees uninitialised contents.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_CLEAR | sweep in progress: one word written per edge, accesses ignored
//   ST_IDLE  | normal operation: reads, writes and clear requests accepted
module ram_sp_sync #(
  parameter int                DATA_W   = 4,
  parameter int                ADDR_W   = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csn,
  input  logic              rwn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                rd_valid_q, rd_valid_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // No reset on the array: only the clear engine initialises it.
  logic [DATA_W-1:0]   mem [DEPTH];

  // Next-state, array write strobe and read-data selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_out_d = '0;
    rd_valid_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = addr;
    mem_wdata  = data_in;

    if (!rst) begin
      unique case (state_q)
        ST_CLEAR: begin
          mem_we    = 1'b1;
          mem_waddr = cnt_q;
          mem_wdata = INIT_VAL;
          // The counter wraps to zero on the same edge that leaves the sweep.
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (clr) begin
            // A clear request wins over any access presented on the same edge.
            state_d = ST_CLEAR;
            cnt_d   = '0;
          end else if (!csn) begin
            if (!rwn) begin
              mem_we = 1'b1;
            end else begin
              data_out_d = mem[addr];
              rd_valid_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Control and output registers with synchronous reset into the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage array: single write port shared by the clear engine and the CPU.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_sp_sync.sv
module tb_ram_sp_sync;

  logic clk;

  // Default-parameter instance (4-bit data, 16 words).
  logic       a_rst, a_csn, a_rwn, a_clr;
  logic [3:0] a_addr, a_din, a_dout;
  logic       a_rdv, a_busy;

  // Wide instance (8-bit data, 32 words, INIT_VAL 0xA5).
  logic       b_rst, b_csn, b_rwn, b_clr;
  logic [4:0] b_addr;
  logic [7:0] b_din, b_dout;
  logic       b_rdv, b_busy;

  logic [3:0] exp_a[$];
  logic [7:0] exp_b[$];
  bit         mon_a_en, mon_b_en;
  int         checks, passes;

  ram_sp_sync u_dut_a (
    .clk(clk), .rst(a_rst), .csn(a_csn), .rwn(a_rwn), .addr(a_addr),
    .data_in(a_din), .clr(a_clr), .data_out(a_dout), .rd_valid(a_rdv),
    .busy(a_busy)
  );

  ram_sp_sync #(.DATA_W(8), .ADDR_W(5), .INIT_VAL(8'hA5)) u_dut_b (
    .clk(clk), .rst(b_rst), .csn(b_csn), .rwn(b_rwn), .addr(b_addr),
    .data_in(b_din), .clr(b_clr), .data_out(b_dout), .rd_valid(b_rdv),
    .busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor A: pop on rd_valid, otherwise outputs must be quiet zeros.
  always @(negedge clk) begin
    if (mon_a_en) begin
      if (a_rdv === 1'b1) begin
        if (exp_a.size() == 0) chk("a_unexpected_rd_valid", 32'(a_dout), 32'hFFFF_FFFF);
        else chk("a_read_data", 32'(a_dout), 32'(exp_a.pop_front()));
      end else begin
        chk("a_quiet_outputs", {27'd0, a_rdv, a_dout}, 32'd0);
      end
    end
  end

  // Monitor B: same rules for the wide instance.
  always @(negedge clk) begin
    if (mon_b_en) begin
      if (b_rdv === 1'b1) begin
        if (exp_b.size() == 0) chk("b_unexpected_rd_valid", 32'(b_dout), 32'hFFFF_FFFF);
        else chk("b_read_data", 32'(b_dout), 32'(exp_b.pop_front()));
      end else begin
        chk("b_quiet_outputs", {23'd0, b_rdv, b_dout}, 32'd0);
      end
    end
  end

  task automatic a_idle();
    a_csn = 1'b1; a_rwn = 1'b1; a_clr = 1'b0; a_addr = '0; a_din = '0;
  endtask

  task automatic a_wr(input logic [3:0] ad, input logic [3:0] d);
    a_csn = 1'b0; a_rwn = 1'b0; a_addr = ad; a_din = d;
    step();
  endtask

  task automatic a_rd(input logic [3:0] ad, input logic [3:0] e);
    a_csn = 1'b0; a_rwn = 1'b1; a_addr = ad;
    exp_a.push_back(e);
    step();
  endtask

  task automatic a_drain(input string name);
    a_idle();
    step(); step();
    chk(name, 32'(exp_a.size()), 32'd0);
  endtask

  // Counts edges until busy falls; optionally pulses clr at a given edge index.
  task automatic a_count_busy(input int clr_at, output int n);
    n = 0;
    do begin
      a_clr = (n == clr_at);
      step();
      n++;
    end while (a_busy === 1'b1 && n < 200);
    a_clr = 1'b0;
  endtask

  task automatic b_rd(input logic [4:0] ad, input logic [7:0] e);
    b_csn = 1'b0; b_rwn = 1'b1; b_addr = ad;
    exp_b.push_back(e);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks = 0; passes = 0;
    mon_a_en = 0; mon_b_en = 0;
    a_rst = 1'b1; a_idle();
    b_rst = 1'b1; b_csn = 1'b1; b_rwn = 1'b1; b_clr = 1'b0; b_addr = '0; b_din = '0;

    // 1. Reset, sweep length, ignored write during busy, all words zero.
    step();
    mon_a_en = 1; mon_b_en = 1;
    step();
    chk("a_busy_in_reset", 32'(a_busy), 32'd1);
    a_rst = 1'b0;
    a_csn = 1'b0; a_rwn = 1'b0; a_addr = 4'd3; a_din = 4'hF;
    n = 0;
    do begin
      step();
      n++;
      if (n == 15) chk("a_busy_before_last", 32'(a_busy), 32'd1);
    end while (a_busy === 1'b1 && n < 200);
    a_idle();
    chk("a_reset_sweep_edges", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) a_rd(4'(i), 4'h0);
    a_drain("a_reset_reads_drained");

    // 2. Write (addr+1)&0xF everywhere, back-to-back read-back.
    for (int i = 0; i < 16; i++) a_wr(4'(i), 4'(i + 1));
    for (int i = 0; i < 16; i++) a_rd(4'(i), 4'(i + 1));
    a_drain("a_sweep_reads_drained");

    // Read immediately after write to the same address.
    a_wr(4'd9, 4'hC);
    a_rd(4'd9, 4'hC);
    a_wr(4'd9, 4'hA);
    a_drain("a_raw_drained");

    // 3. Deselected write must not land and must leave outputs quiet.
    a_rd(4'd1, 4'h2);
    a_csn = 1'b1; a_rwn = 1'b0; a_addr = 4'd5; a_din = 4'hA;
    step();
    chk("a_deselect_outputs", {27'd0, a_rdv, a_dout}, 32'd0);
    a_rd(4'd5, 4'h6);
    a_drain("a_deselect_drained");

    // 4. clr together with a read: read discarded, clr while busy ignored.
    a_clr = 1'b1; a_csn = 1'b0; a_rwn = 1'b1; a_addr = 4'd2;
    step();
    a_idle();
    chk("a_busy_after_clr", 32'(a_busy), 32'd1);
    chk("a_no_rdv_after_clr", 32'(a_rdv), 32'd0);
    a_count_busy(5, n);
    chk("a_clr_sweep_edges", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) a_rd(4'(i), 4'h0);
    a_drain("a_clr_reads_drained");

    // 5. Reset at sweep count 7 restarts the full sweep.
    for (int i = 0; i < 4; i++) a_wr(4'(i), 4'h7);
    a_rst = 1'b1;
    step();
    a_rst = 1'b0;
    repeat (7) step();
    chk("a_busy_mid_sweep", 32'(a_busy), 32'd1);
    a_rst = 1'b1;
    step();
    chk("a_busy_during_rst", 32'(a_busy), 32'd1);
    a_rst = 1'b0;
    a_count_busy(-1, n);
    chk("a_restart_sweep_edges", 32'(n), 32'd16);
    for (int i = 0; i < 4; i++) a_rd(4'(i), 4'h0);
    a_rd(4'd15, 4'h0);
    a_drain("a_restart_reads_drained");

    // 6. Wide instance: 32-edge sweep to 0xA5, write/read at the top address.
    b_rst = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (b_busy === 1'b1 && n < 200);
    chk("b_sweep_edges", 32'(n), 32'd32);
    for (int i = 0; i < 32; i++) b_rd(5'(i), 8'hA5);
    b_csn = 1'b0; b_rwn = 1'b0; b_addr = 5'd31; b_din = 8'h3C;
    step();
    b_rd(5'd31, 8'h3C);
    b_rd(5'd0, 8'hA5);
    b_csn = 1'b1; b_rwn = 1'b1;
    step(); step();
    chk("b_reads_drained", 32'(exp_b.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ram_sp_sync.md
Name: ram_sp_sync

Overview:
- Parametrised single-port synchronous RAM. Successor to the fixed 16x4 CPU RAM.
- Data width and address width are configurable.
- Read data is registered with a read-valid flag.
- A built-in clear engine sweeps every location to a known value after reset or on request, so the CPU data path never reads X.

Parameters:
- DATA_W, 4, data word width in bits (>=1).
- ADDR_W, 4, address width in bits (>=1). Depth is 2**ADDR_W, so every address is valid.
- INIT_VAL, 0, value of width DATA_W written to every location by the clear engine.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- csn  input  1  chip select, active low.
- rwn  input  1  1 = read, 0 = write; sampled only when csn=0.
- addr  input  ADDR_W  word address.
- data_in  input  DATA_W  write data.
- clr  input  1  single-cycle request to re-initialise the memory array.
- data_out  output  DATA_W  registered read data.
- rd_valid  output  1  high for one cycle when data_out holds read data.
- busy  output  1  clear engine active; all accesses are ignored.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-high, port rst. All registers update on the rising edge of clk.
- FSM states: CLEAR and IDLE.
- Reset (rst=1 at an edge):
  - state=CLEAR, clear counter=0.
  - busy=1, data_out=0, rd_valid=0.
  - No array writes occur while rst=1.
  - Reset mid-clear or mid-access restarts the sweep from address 0.
- CLEAR state, per edge with rst=0:
  - Write mem[cnt]<=INIT_VAL, then cnt<=cnt+1.
  - On the edge that writes address 2**ADDR_W-1: state<=IDLE, busy<=0.
  - Result: busy stays high for exactly 2**ADDR_W edges after rst deasserts.
  - The counter is ADDR_W bits wide; its wrap to 0 coincides with the exit to IDLE.
- In CLEAR:
  - csn, rwn, addr, data_in and clr are ignored.
  - data_out=0, rd_valid=0.
- IDLE state, per edge with rst=0, in priority order:
  1. clr=1: state<=CLEAR, cnt<=0, busy<=1, data_out<=0, rd_valid<=0. A simultaneous access request is discarded. The sweep then takes 2**ADDR_W further edges.
  2. csn=0, rwn=0: mem[addr]<=data_in, data_out<=0, rd_valid<=0.
  3. csn=0, rwn=1: data_out<=mem[addr], rd_valid<=1.
  4. csn=1: data_out<=0, rd_valid<=0. The array is unchanged.
- Read latency: a request sampled at edge N produces data_out/rd_valid visible after edge N.
  - Back-to-back reads give one word per cycle.
  - rd_valid drops the cycle after the last read request.
- Read-after-write:
  - A write at edge N followed by a read of the same address at edge N+1 returns the new data.
  - A single port means no same-edge read/write conflict exists.
- Width rules:
  - data_in and INIT_VAL are stored unmodified.
  - The array is not reset by rst directly; only the clear engine initialises it.
- Outputs never carry X after the first reset edge.

Test Plan (defaults DATA_W=4, ADDR_W=4 unless stated):
1. Reset/clear:
   - Stimulus: rst=1 for 2 edges, then rst=0.
   - Required: busy=1 for exactly 16 edges, then 0. data_out=0 and rd_valid=0 throughout. Reading all 16 addresses afterwards returns 0x0, each with rd_valid=1.
2. Write/read sweep:
   - Stimulus: write (addr+1)&0xF to addresses 0..15, one per cycle, then read 0..15 back-to-back.
   - Required: each read returns addr+1 (address 15 returns 0x0) one edge after the request. rd_valid stays high for 16 consecutive cycles, then falls.
3. Chip-select and ignored accesses:
   - Stimulus: csn=1, rwn=0, addr=5, data_in=0xA for 1 edge, then read addr 5.
   - Required: data_out=0 and rd_valid=0 after the deselected edge. The read returns the prior value 0x6, not 0xA.
   - Stimulus: during busy, attempt a write of 0xF to addr 3.
   - Required: after busy falls, addr 3 reads INIT_VAL.
4. clr with simultaneous access:
   - Stimulus: in IDLE with memory filled, assert clr=1 together with csn=0, rwn=1, addr=2.
   - Required: rd_valid stays 0 and busy rises the next cycle for 16 edges. All locations then read 0x0. A clr pulse issued while busy has no effect: busy does not extend.
5. Reset mid-clear:
   - Stimulus: assert rst for 1 edge at sweep count 7.
   - Required: busy stays high and the sweep restarts, needing 16 full edges after rst falls.
6. Parametrised instance (DATA_W=8, ADDR_W=5, INIT_VAL=8'hA5):
   - Required: busy lasts 32 edges and all 32 words read 0xA5.
   - Stimulus: write 0x3C to addr 31, then read it.
   - Required: the read returns 0x3C, and addr 0 still reads 0xA5.
